stream_switch_select_ctrl: RTL

- Next-generation AXI-Lite control block for stream-switch DFX demux/mux select lines.
- Holds staged and committed select values for NUM_CH independent channels.
- A commit applies to a channel mask, and each channel switches only at a packet boundary of its monitored AXI-Stream port.
- Commits still blocked when a timeout expires are aborted and flagged.

---
 rtl/stream_switch_select_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/stream_switch_select_ctrl.sv
// stream_switch_select_ctrl: AXI-Lite staged/committed stream-switch selects, packet-boundary commit with timeout; STREAM_SWITCH_SELECT_IRQ_EN adds irq + IRQ_EN reg
module stream_switch_select_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int M_COUNT        = 2,
  parameter int SEL_W          = $clog2(M_COUNT),
  parameter int COMMIT_TIMEOUT = 1024
) (
  input  logic                    axil_aclk,
  input  logic                    axil_aresetn,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [7:0]              s_axil_awaddr,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  input  logic [31:0]             s_axil_wdata,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  output logic [1:0]              s_axil_bresp,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  input  logic [7:0]              s_axil_araddr,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [31:0]             s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  input  logic [NUM_CH-1:0]       mon_tvalid,
  input  logic [NUM_CH-1:0]       mon_tready,
  input  logic [NUM_CH-1:0]       mon_tlast,
  output logic [NUM_CH*SEL_W-1:0] select_committed
`ifdef STREAM_SWITCH_SELECT_IRQ_EN
  , output logic                  irq
`endif
);
  localparam int CW = $clog2(COMMIT_TIMEOUT) + 1;
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  r_state;
  logic                    r_awready, r_arready, r_bvalid, r_rvalid, r_sticky;
  logic [1:0]              r_bresp, r_rresp;
  logic [31:0]             r_rdata;
  logic [NUM_CH*SEL_W-1:0] r_sel;
  logic [SEL_W-1:0]        r_stg [NUM_CH];
  logic [NUM_CH-1:0]       r_pend, r_in_pkt;
  logic [CW-1:0]           r_cnt;
`ifdef STREAM_SWITCH_SELECT_IRQ_EN
  logic [1:0]              r_irq_en;
  logic                    r_irq;
  assign irq = r_irq;
`endif

  logic              w_wr, w_rd, w_busy, w_werr, w_rmap, w_commit, w_clr, w_tmo, w_unused;
  logic [5:0]        w_widx, w_ridx;
  logic [NUM_CH-1:0] w_in_nx, w_safe, w_left, w_stg_we, w_mask;
  logic [31:0]       w_rdata;

  assign w_wr     = r_awready & s_axil_awvalid & s_axil_wvalid;
  assign w_rd     = r_arready & s_axil_arvalid;
  assign w_widx   = s_axil_awaddr[7:2];
  assign w_ridx   = s_axil_araddr[7:2];
  assign w_mask   = s_axil_wdata[NUM_CH-1:0];
  assign w_busy   = r_state == S_WAIT;
  // a channel is safe to switch once it sits outside a packet after this edge
  assign w_in_nx  = (mon_tvalid & mon_tready & ~mon_tlast) | (~(mon_tvalid & mon_tready) & r_in_pkt);
  assign w_safe   = r_pend & ~w_in_nx;
  assign w_left   = r_pend & w_in_nx;
  assign w_tmo    = w_busy & (r_cnt == CW'(COMMIT_TIMEOUT - 1)) & (|w_left);
  assign w_commit = w_wr & (w_widx == 6'd0) & ~w_busy & (|w_mask);
  assign w_clr    = w_wr & (w_widx == 6'd1) & s_axil_wdata[1];
  assign w_unused = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_wdata};

  assign s_axil_awready   = r_awready;
  assign s_axil_wready    = r_awready;
  assign s_axil_bvalid    = r_bvalid;
  assign s_axil_bresp     = r_bresp;
  assign s_axil_arready   = r_arready;
  assign s_axil_rvalid    = r_rvalid;
  assign s_axil_rdata     = r_rdata;
  assign s_axil_rresp     = r_rresp;
  assign select_committed = r_sel;

  always_comb begin
    w_werr   = 1'b1;
    w_stg_we = '0;
    if (w_widx == 6'd0) w_werr = w_busy;
    if (w_widx == 6'd1) w_werr = 1'b0;
`ifdef STREAM_SWITCH_SELECT_IRQ_EN
    if (w_widx == 6'd2) w_werr = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_widx == 6'(4 + i)) begin
        w_werr      = r_pend[i];
        w_stg_we[i] = w_wr & ~r_pend[i];
      end
      if (w_widx == 6'(16 + i)) w_werr = 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    w_rmap  = 1'b0;
    if (w_ridx == 6'd0) begin
      w_rdata[NUM_CH-1:0] = r_pend;
      w_rmap = 1'b1;
    end
    if (w_ridx == 6'd1) begin
      w_rdata[1:0] = {r_sticky, w_busy};
      w_rmap = 1'b1;
    end
`ifdef STREAM_SWITCH_SELECT_IRQ_EN
    if (w_ridx == 6'd2) begin
      w_rdata[1:0] = r_irq_en;
      w_rmap = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ridx == 6'(4 + i)) begin
        w_rdata[SEL_W-1:0] = r_stg[i];
        w_rmap = 1'b1;
      end
      if (w_ridx == 6'(16 + i)) begin
        w_rdata[SEL_W-1:0] = r_sel[i*SEL_W +: SEL_W];
        w_rmap = 1'b1;
      end
    end
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_state   <= S_IDLE;
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_sel     <= '0;
      r_pend    <= '0;
      r_in_pkt  <= '0;
      r_sticky  <= 1'b0;
      r_cnt     <= '0;
      for (int i = 0; i < NUM_CH; i++) r_stg[i] <= '0;
`ifdef STREAM_SWITCH_SELECT_IRQ_EN
      r_irq_en  <= 2'b00;
      r_irq     <= 1'b0;
`endif
    end else begin
      r_awready <= s_axil_awvalid & s_axil_wvalid & ~r_bvalid & ~r_awready;
      r_arready <= s_axil_arvalid & ~r_rvalid & ~r_arready;
      if (w_wr) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_werr ? 2'b10 : 2'b00;
      end else if (s_axil_bready) r_bvalid <= 1'b0;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= w_rmap ? 2'b00 : 2'b10;
      end else if (s_axil_rready) r_rvalid <= 1'b0;
      r_in_pkt <= w_in_nx;
      for (int i = 0; i < NUM_CH; i++) if (w_stg_we[i]) r_stg[i] <= s_axil_wdata[SEL_W-1:0];
      // a timeout setting the sticky bit overrides a simultaneous clear
      r_sticky <= w_tmo | (r_sticky & ~w_clr);
      if (r_state == S_IDLE) begin
        if (w_commit) begin
          r_pend  <= w_mask;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
      end else begin
        for (int i = 0; i < NUM_CH; i++) if (w_safe[i]) r_sel[i*SEL_W +: SEL_W] <= r_stg[i];
        r_cnt <= r_cnt + 1'b1;
        if (w_left == '0 || w_tmo) begin
          r_pend  <= '0;
          r_state <= S_IDLE;
        end else r_pend <= w_left;
      end
`ifdef STREAM_SWITCH_SELECT_IRQ_EN
      if (w_wr && w_widx == 6'd2) r_irq_en <= s_axil_wdata[1:0];
      r_irq <= (r_irq & ~(w_wr & (w_widx == 6'd2))) | (w_busy & (((w_left == '0) & r_irq_en[0]) | (w_tmo & r_irq_en[1])));
`endif
    end
  end
endmodule
